// File: rtl/step_sequencer_pkg.sv
// Shared environment definitions: FSM state encoding, default word widths and the WAIT timeout.
package step_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FIRE = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    localparam int DEF_PE_NUM  = 40;
    localparam int DEF_STA_WL  = 64;
    localparam int DEF_ACT_WL  = 32;
    localparam int DEF_OBS_WL  = 96;
    localparam int DEF_RWD_WL  = 32;
    localparam int DEF_TIMEOUT = 1024;

    // Counter width that still works for a single environment.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Action stream and result handshake between the host and the step sequencer.
interface step_sequencer_if
    import step_sequencer_pkg::*;
#(
    parameter int PE_NUM = DEF_PE_NUM,
    parameter int ACT_WL = DEF_ACT_WL,
    parameter int OBS_WL = DEF_OBS_WL,
    parameter int RWD_WL = DEF_RWD_WL
);
    logic                     i_act_valid;
    logic                     o_act_ready;
    logic [ACT_WL-1:0]        i_act_data;
    logic                     o_res_valid;
    logic                     i_res_ready;
    logic [PE_NUM*OBS_WL-1:0] o_obs;
    logic [PE_NUM*RWD_WL-1:0] o_rwd;
    logic [PE_NUM-1:0]        o_done;

    modport master (
        output i_act_valid, i_act_data, i_res_ready,
        input  o_act_ready, o_res_valid, o_obs, o_rwd, o_done
    );

    modport slave (
        input  i_act_valid, i_act_data, i_res_ready,
        output o_act_ready, o_res_valid, o_obs, o_rwd, o_done
    );
endinterface

// File: rtl/step_sequencer_act_deserializer.sv
// Collects one action per environment into the action bank, in environment order.
module act_deserializer
    import step_sequencer_pkg::*;
#(
    parameter int PE_NUM = DEF_PE_NUM,
    parameter int ACT_WL = DEF_ACT_WL
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_beat,
    input  logic [ACT_WL-1:0]        i_act_data,
    output logic                     o_last,
    output logic [PE_NUM*ACT_WL-1:0] o_act
);
    localparam int              IDX_W    = idx_width(PE_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PE_NUM - 1);

    logic [IDX_W-1:0]               r_idx;
    logic [PE_NUM-1:0][ACT_WL-1:0]  r_bank;

    assign o_last = i_beat && (r_idx == LAST_IDX);
    assign o_act  = r_bank;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_bank <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_beat) begin
            r_bank[r_idx] <= i_act_data;
            r_idx         <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end
endmodule

// File: rtl/step_sequencer.sv
// Drives one environment step: gather actions, strobe the compute array, capture results with
// per-environment auto-reset, and hand the result bundle to the host.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int PE_NUM  = DEF_PE_NUM,
    parameter int STA_WL  = DEF_STA_WL,
    parameter int ACT_WL  = DEF_ACT_WL,
    parameter int OBS_WL  = DEF_OBS_WL,
    parameter int RWD_WL  = DEF_RWD_WL,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_init,
    input  logic [PE_NUM*STA_WL-1:0] i_sta_init,
    step_sequencer_if.slave          io_bus,
    output logic                     o_ena,
    output logic [PE_NUM*STA_WL-1:0] o_sta,
    output logic [PE_NUM*ACT_WL-1:0] o_act,
    input  logic [PE_NUM*STA_WL-1:0] i_sta,
    input  logic [PE_NUM*OBS_WL-1:0] i_obs,
    input  logic [PE_NUM*RWD_WL-1:0] i_rwd,
    input  logic [PE_NUM-1:0]        i_done,
    input  logic                     i_valid,
    output logic [31:0]              o_step_cnt,
    output logic                     o_busy,
    output logic                     o_err
);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    state_t                         r_state, w_next;
    logic [WC_W-1:0]                r_wcnt;
    logic [PE_NUM-1:0][STA_WL-1:0]  r_init, r_sta;
    logic [PE_NUM*OBS_WL-1:0]       r_obs;
    logic [PE_NUM*RWD_WL-1:0]       r_rwd;
    logic [PE_NUM-1:0]              r_done;
    logic [31:0]                    r_step_cnt;
    logic                           r_err;
    logic                           w_init_acc, w_beat, w_last, w_cap, w_tmo;
    logic                           w_act_ready, w_res_valid;

    // i_init wins over a same-cycle action beat, so the beat is masked here.
    assign w_init_acc = i_init && (r_state == ST_IDLE || r_state == ST_LOAD);
    assign w_beat     = (r_state == ST_LOAD) && io_bus.i_act_valid && !i_init;
    assign w_cap      = (r_state == ST_WAIT) && i_valid;
    assign w_tmo      = (r_state == ST_WAIT) && !i_valid && (r_wcnt == WC_W'(TIMEOUT - 1));

    act_deserializer #(.PE_NUM(PE_NUM), .ACT_WL(ACT_WL)) u_deser (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_init_acc),
        .i_beat     (w_beat),
        .i_act_data (io_bus.i_act_data),
        .o_last     (w_last),
        .o_act      (o_act)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_init) w_next = ST_LOAD;
            ST_LOAD: if (w_last) w_next = ST_FIRE;
            ST_FIRE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_cap)      w_next = ST_OUT;
                else if (w_tmo) w_next = ST_IDLE;
            end
            ST_OUT:  if (io_bus.i_res_ready) w_next = ST_LOAD;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ena       = 1'b0;
        o_busy      = 1'b0;
        w_act_ready = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            ST_LOAD: w_act_ready = 1'b1;
            ST_FIRE: begin o_ena = 1'b1; o_busy = 1'b1; end
            ST_WAIT: o_busy = 1'b1;
            ST_OUT:  w_res_valid = 1'b1;
            default: ;
        endcase
    end

    // A finished environment restarts from its init state; the raw done flags still go out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_init     <= '0;
            r_sta      <= '0;
            r_obs      <= '0;
            r_rwd      <= '0;
            r_done     <= '0;
            r_step_cnt <= '0;
            r_wcnt     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_init_acc) begin
                r_init <= i_sta_init;
                r_sta  <= i_sta_init;
            end else if (w_cap) begin
                for (int k = 0; k < PE_NUM; k++)
                    r_sta[k] <= i_done[k] ? r_init[k] : i_sta[k*STA_WL +: STA_WL];
            end
            if (w_cap) begin
                r_obs      <= i_obs;
                r_rwd      <= i_rwd;
                r_done     <= i_done;
                r_step_cnt <= r_step_cnt + 32'd1;
            end
            if (r_state == ST_FIRE)      r_wcnt <= '0;
            else if (r_state == ST_WAIT) r_wcnt <= r_wcnt + 1'b1;
            if (w_tmo) r_err <= 1'b1;
        end
    end

    assign o_sta              = r_sta;
    assign o_step_cnt         = r_step_cnt;
    assign o_err              = r_err;
    assign io_bus.o_act_ready = w_act_ready;
    assign io_bus.o_res_valid = w_res_valid;
    assign io_bus.o_obs       = r_obs;
    assign io_bus.o_rwd       = r_rwd;
    assign io_bus.o_done      = r_done;
endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer with a small environment array and short timeout.
module tb_step_sequencer;
    localparam int PE = 4;
    localparam int SW = 64;
    localparam int AW = 32;
    localparam int OW = 96;
    localparam int RW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst, init, ena, i_valid, busy, err;
    logic [PE*SW-1:0] sta_init, o_sta, i_sta;
    logic [PE*AW-1:0] o_act;
    logic [PE*OW-1:0] i_obs;
    logic [PE*RW-1:0] i_rwd;
    logic [PE-1:0]    i_done;
    logic [31:0]      step_cnt;

    step_sequencer_if #(.PE_NUM(PE), .ACT_WL(AW), .OBS_WL(OW), .RWD_WL(RW)) bus ();

    step_sequencer #(.PE_NUM(PE), .STA_WL(SW), .ACT_WL(AW), .OBS_WL(OW), .RWD_WL(RW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_init(init), .i_sta_init(sta_init), .io_bus(bus),
        .o_ena(ena), .o_sta(o_sta), .o_act(o_act), .i_sta(i_sta), .i_obs(i_obs),
        .i_rwd(i_rwd), .i_done(i_done), .i_valid(i_valid), .o_step_cnt(step_cnt),
        .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PE*OW-1:0] obs;
        logic [PE*RW-1:0] rwd;
        logic [PE-1:0]    done;
        logic [PE*SW-1:0] sta;
        logic [31:0]      cnt;
    } exp_t;

    exp_t        sb[$];
    int          errs = 0;
    int          checks = 0;
    logic [63:0] m_init[PE];
    logic [63:0] m_sta[PE];
    logic [31:0] m_cnt;
    logic [31:0] cur_act[PE];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PE*SW-1:0] flat_sta();
        logic [PE*SW-1:0] r;
        for (int k = 0; k < PE; k++) r[k*SW +: SW] = m_sta[k];
        return r;
    endfunction

    function automatic logic [PE*AW-1:0] flat_act();
        logic [PE*AW-1:0] r;
        for (int k = 0; k < PE; k++) r[k*AW +: AW] = cur_act[k];
        return r;
    endfunction

    task automatic do_init(input logic [63:0] base);
        for (int k = 0; k < PE; k++) begin
            sta_init[k*SW +: SW] = base * 64'(k + 1);
            m_init[k] = base * 64'(k + 1);
            m_sta[k]  = base * 64'(k + 1);
        end
        init = 1'b1;
        tick();
        init = 1'b0;
        checks++; if (bus.o_act_ready !== 1'b1) begin errs++; $display("FAIL init_to_load: got %b want 1", bus.o_act_ready); end
        checks++; if (o_sta !== flat_sta()) begin errs++; $display("FAIL init_sta: got %h want %h", o_sta, flat_sta()); end
    endtask

    task automatic send_beats();
        for (int i = 0; i < PE; i++) begin
            bus.i_act_valid = 1'b1;
            bus.i_act_data  = cur_act[i];
            tick();
            if (i < PE - 1) begin
                checks++; if (ena !== 1'b0) begin errs++; $display("FAIL early_ena beat %0d: got %b want 0", i, ena); end
            end
        end
        bus.i_act_valid = 1'b0;
        checks++; if (ena !== 1'b1) begin errs++; $display("FAIL ena_after_last: got %b want 1", ena); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_fire: got %b want 1", busy); end
        checks++; if (o_act !== flat_act()) begin errs++; $display("FAIL act_bank: got %h want %h", o_act, flat_act()); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (ena !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rst_ena_busy: got %b%b want 00", ena, busy); end
        checks++; if (err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (step_cnt !== 32'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", step_cnt); end
        checks++; if (bus.o_res_valid !== 1'b0 || bus.o_act_ready !== 1'b0) begin errs++; $display("FAIL rst_hs: got %b%b want 00", bus.o_res_valid, bus.o_act_ready); end
        checks++; if (o_sta !== '0 || o_act !== '0) begin errs++; $display("FAIL rst_banks: got %h / %h want 0", o_sta, o_act); end
        checks++; if (bus.o_obs !== '0 || bus.o_rwd !== '0 || bus.o_done !== '0) begin errs++; $display("FAIL rst_bundle: got %h %h %b want 0", bus.o_obs, bus.o_rwd, bus.o_done); end
    endtask

    // One full step: beats, compute response 5 cycles after o_ena, capture, hold, release.
    task automatic test_step(input logic [PE-1:0] dmask, input int hold_n, input bit poke_init);
        exp_t        e;
        logic [63:0] nxt;
        send_beats();
        for (int k = 0; k < PE; k++) begin
            nxt = m_sta[k] + 64'(cur_act[k]) + 64'h1000;
            i_sta[k*SW +: SW] = nxt;
            i_obs[k*OW +: OW] = {32'(k), 32'hA5A5_0000, cur_act[k] * 32'd5};
            i_rwd[k*RW +: RW] = 32'd7;
            m_sta[k] = dmask[k] ? m_init[k] : nxt;
        end
        i_done = dmask;
        m_cnt  = m_cnt + 32'd1;
        e.obs = i_obs; e.rwd = i_rwd; e.done = dmask; e.sta = flat_sta(); e.cnt = m_cnt;
        sb.push_back(e);
        tick();
        checks++; if (ena !== 1'b0) begin errs++; $display("FAIL ena_one_cycle: got %b want 0", ena); end
        if (poke_init) begin
            sta_init = '1;
            init = 1'b1;
            tick();
            init = 1'b0;
            repeat (3) tick();
        end else begin
            repeat (4) tick();
        end
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_obs = ~i_obs;
        i_rwd = ~i_rwd;
        checks++; if (bus.o_res_valid !== 1'b1) begin errs++; $display("FAIL res_latency: got %b want 1", bus.o_res_valid); end
        e = sb.pop_front();
        checks++; if (bus.o_obs !== e.obs) begin errs++; $display("FAIL res_obs: got %h want %h", bus.o_obs, e.obs); end
        checks++; if (bus.o_rwd !== e.rwd) begin errs++; $display("FAIL res_rwd: got %h want %h", bus.o_rwd, e.rwd); end
        checks++; if (bus.o_done !== e.done) begin errs++; $display("FAIL res_done: got %b want %b", bus.o_done, e.done); end
        checks++; if (step_cnt !== e.cnt) begin errs++; $display("FAIL res_cnt: got %0d want %0d", step_cnt, e.cnt); end
        checks++; if (o_sta !== e.sta) begin errs++; $display("FAIL res_sta: got %h want %h", o_sta, e.sta); end
        for (int h = 0; h < hold_n; h++) begin
            tick();
            checks++; if (bus.o_res_valid !== 1'b1 || bus.o_act_ready !== 1'b0) begin errs++; $display("FAIL hold_hs %0d: got %b%b want 10", h, bus.o_res_valid, bus.o_act_ready); end
            checks++; if (bus.o_obs !== e.obs || bus.o_rwd !== e.rwd || step_cnt !== e.cnt) begin errs++; $display("FAIL hold_bundle %0d: got %h %h %0d want %h %h %0d", h, bus.o_obs, bus.o_rwd, step_cnt, e.obs, e.rwd, e.cnt); end
        end
        bus.i_res_ready = 1'b1;
        tick();
        bus.i_res_ready = 1'b0;
        checks++; if (bus.o_res_valid !== 1'b0 || bus.o_act_ready !== 1'b1) begin errs++; $display("FAIL out_to_load: got %b%b want 01", bus.o_res_valid, bus.o_act_ready); end
    endtask

    task automatic test_auto_reset();
        cur_act[0] = 32'd1; cur_act[1] = 32'd2; cur_act[2] = 32'd3; cur_act[3] = 32'd4;
        test_step(4'b0010, 10, 1'b0);
        checks++; if (o_sta[SW +: SW] !== 64'h20) begin errs++; $display("FAIL auto_reset_slot1: got %h want 20", o_sta[SW +: SW]); end
        checks++; if (bus.o_rwd !== {PE{32'd7}}) begin errs++; $display("FAIL rwd_all7: got %h", bus.o_rwd); end
        checks++; if (step_cnt !== 32'd1) begin errs++; $display("FAIL first_cnt: got %0d want 1", step_cnt); end
    endtask

    task automatic test_init_abort();
        bus.i_act_valid = 1'b1;
        bus.i_act_data  = 32'd9;
        tick(); tick();
        for (int k = 0; k < PE; k++) begin
            sta_init[k*SW +: SW] = 64'h111 * 64'(k + 1);
            m_init[k] = 64'h111 * 64'(k + 1);
            m_sta[k]  = 64'h111 * 64'(k + 1);
        end
        init = 1'b1;
        bus.i_act_data = 32'hDEAD;
        tick();
        init = 1'b0;
        bus.i_act_valid = 1'b0;
        checks++; if (bus.o_act_ready !== 1'b1) begin errs++; $display("FAIL abort_in_load: got %b want 1", bus.o_act_ready); end
        checks++; if (o_sta !== flat_sta()) begin errs++; $display("FAIL abort_reload: got %h want %h", o_sta, flat_sta()); end
        cur_act[0] = 32'd5; cur_act[1] = 32'd6; cur_act[2] = 32'd7; cur_act[3] = 32'd8;
        test_step(4'b1001, 0, 1'b0);
    endtask

    task automatic test_timeout();
        int n;
        cur_act[0] = 32'd11; cur_act[1] = 32'd12; cur_act[2] = 32'd13; cur_act[3] = 32'd14;
        send_beats();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy !== 1'b1) break;
            n++;
        end
        checks++; if (n !== TO) begin errs++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
        checks++; if (err !== 1'b1) begin errs++; $display("FAIL timeout_err: got %b want 1", err); end
        checks++; if (bus.o_act_ready !== 1'b0 || bus.o_res_valid !== 1'b0) begin errs++; $display("FAIL timeout_idle: got %b%b want 00", bus.o_act_ready, bus.o_res_valid); end
        checks++; if (step_cnt !== m_cnt) begin errs++; $display("FAIL timeout_cnt: got %0d want %0d", step_cnt, m_cnt); end
        checks++; if (o_sta !== flat_sta()) begin errs++; $display("FAIL timeout_sta: got %h want %h", o_sta, flat_sta()); end
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        checks++; if (step_cnt !== m_cnt || bus.o_res_valid !== 1'b0) begin errs++; $display("FAIL idle_valid_ignored: got %0d %b want %0d 0", step_cnt, bus.o_res_valid, m_cnt); end
        checks++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_rst_mid();
        do_init(64'h10);
        send_beats();
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < PE; k++) begin m_init[k] = '0; m_sta[k] = '0; end
        m_cnt = '0;
        checks++; if (busy !== 1'b0 || ena !== 1'b0 || err !== 1'b0) begin errs++; $display("FAIL midrst_ctrl: got %b%b%b want 000", busy, ena, err); end
        checks++; if (o_sta !== '0 || o_act !== '0 || step_cnt !== 32'd0) begin errs++; $display("FAIL midrst_data: got %h %h %0d want 0", o_sta, o_act, step_cnt); end
        i_valid = 1'b1;
        tick(); tick();
        i_valid = 1'b0;
        checks++; if (bus.o_res_valid !== 1'b0 || step_cnt !== 32'd0 || o_sta !== '0) begin errs++; $display("FAIL midrst_valid: got %b %0d %h want 0", bus.o_res_valid, step_cnt, o_sta); end
    endtask

    task automatic test_no_init();
        cur_act[0] = 32'd21; cur_act[1] = 32'd22; cur_act[2] = 32'd23; cur_act[3] = 32'd24;
        for (int i = 0; i < PE + 2; i++) begin
            bus.i_act_valid = 1'b1;
            bus.i_act_data  = 32'd77;
            tick();
            checks++; if (ena !== 1'b0 || bus.o_act_ready !== 1'b0) begin errs++; $display("FAIL no_init_step %0d: got %b%b want 00", i, ena, bus.o_act_ready); end
        end
        bus.i_act_valid = 1'b0;
        do_init(64'h40);
        test_step(4'b0000, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; init = 1'b0; i_valid = 1'b0;
        sta_init = '0; i_sta = '0; i_obs = '0; i_rwd = '0; i_done = '0;
        bus.i_act_valid = 1'b0; bus.i_act_data = '0; bus.i_res_ready = 1'b0;
        m_cnt = '0;
        for (int k = 0; k < PE; k++) begin m_init[k] = '0; m_sta[k] = '0; cur_act[k] = '0; end
        tick();
        test_reset();
        do_init(64'h10);
        test_auto_reset();
        cur_act[0] = 32'hAA; cur_act[1] = 32'hBB; cur_act[2] = 32'hCC; cur_act[3] = 32'hDD;
        test_step(4'b0101, 2, 1'b1);
        test_init_abort();
        test_timeout();
        test_rst_mid();
        test_no_init();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
